// File: rtl/memacc_pkg.sv
// Shared types and access-formatting helpers for the RV32 memory stage.
// Access size is taken from funct3; unlisted encodings fall back to a word access.
package memacc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  typedef struct packed {
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } store_t;

  function automatic size_t acc_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

  function automatic logic acc_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (acc_size(f3))
      SZ_H:    return off[0];
      SZ_W:    return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Offsets are masked to natural alignment, so halfwords only look at off[1].
  function automatic store_t store_fmt(input logic [2:0] f3, input logic [1:0] off,
                                       input logic [31:0] data);
    store_t s;
    case (acc_size(f3))
      SZ_B: begin
        s.wdata = {4{data[7:0]}};
        s.wstrb = 4'b0001 << off;
      end
      SZ_H: begin
        s.wdata = {2{data[15:0]}};
        s.wstrb = 4'b0011 << {off[1], 1'b0};
      end
      default: begin
        s.wdata = data;
        s.wstrb = 4'b1111;
      end
    endcase
    return s;
  endfunction

  function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [31:0] sh;
    logic [15:0] half;
    sh   = word >> {off, 3'b000};
    half = off[1] ? word[31:16] : word[15:0];
    case (acc_size(f3))
      SZ_B:    return (f3 == F3_B) ? {{24{sh[7]}}, sh[7:0]} : {24'b0, sh[7:0]};
      SZ_H:    return (f3 == F3_H) ? {{16{half[15]}}, half} : {16'b0, half};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Load lane select and sign/zero extension of the memory response word.
// Purely combinational; no state, no backpressure.
// Offset is masked to the natural alignment of the access size.
module load_align
  import memacc_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  output logic [31:0] ldata
);

  assign ldata = load_fmt(funct3, offset, rdata);

endmodule

// File: rtl/memory_access.sv
// RV32 memory stage: loads/stores over a valid/ready dmem request plus response channel.
// Latency: ALU ops 1 cycle, stores 2, loads 3, plus one per late ready/response cycle.
// Backpressure: combinational stall held while an access is outstanding. Option: MEMACC_MISALIGN_TRAP_EN.
module memory_access
  import memacc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            inValid,
  input  logic [XLEN-1:0] aluResult,
  input  logic [XLEN-1:0] storeData,
  input  logic            memRead,
  input  logic            memWrite,
  input  logic [2:0]      funct3,
  input  logic [4:0]      rd,
  input  logic            regWrite,
  output logic            stall,
  output logic            dmemReqValid,
  input  logic            dmemReqReady,
  output logic [XLEN-1:0] dmemAddr,
  output logic            dmemWe,
  output logic [3:0]      dmemWstrb,
  output logic [XLEN-1:0] dmemWdata,
  input  logic            dmemRspValid,
  input  logic [XLEN-1:0] dmemRspData,
  output logic            wbValid,
  output logic [XLEN-1:0] wbData,
  output logic [4:0]      wbRd,
  output logic            wbRegWrite
`ifdef MEMACC_MISALIGN_TRAP_EN
  ,
  output logic            misaligned
`endif
);

  state_t      state, state_nx;
  logic [31:0] alu_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic        rw_q;
  logic        we_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q;
  logic [31:0] ld_data;
  logic        is_mem;
  logic        mis_in;
  logic        take_mem;
  store_t      sfmt;

  assign is_mem = memRead | memWrite;
`ifdef MEMACC_MISALIGN_TRAP_EN
  assign mis_in = is_mem & acc_misaligned(funct3, aluResult[1:0]);
`else
  assign mis_in = 1'b0;
`endif
  assign take_mem = (state == ST_IDLE) & inValid & is_mem & ~mis_in;
  assign sfmt     = store_fmt(funct3, aluResult[1:0], storeData);

  load_align u_load_align (
    .funct3 (f3_q),
    .offset (alu_q[1:0]),
    .rdata  (dmemRspData),
    .ldata  (ld_data)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (take_mem) state_nx = ST_REQ;
      ST_REQ:  if (dmemReqReady) state_nx = we_q ? ST_IDLE : ST_RESP;
      ST_RESP: if (dmemRspValid) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    dmemReqValid = 1'b0;
    stall        = 1'b0;
    case (state)
      ST_IDLE: stall = take_mem;
      ST_REQ: begin
        dmemReqValid = 1'b1;
        stall        = ~(dmemReqReady & we_q);
      end
      ST_RESP: stall = ~dmemRspValid;
      default: ;
    endcase
  end

  assign dmemAddr  = {alu_q[31:2], 2'b00};
  assign dmemWe    = we_q;
  assign dmemWstrb = wstrb_q;
  assign dmemWdata = wdata_q;

  // Request fields are latched once in IDLE and held untouched until acceptance.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      alu_q      <= '0;
      f3_q       <= '0;
      rd_q       <= '0;
      rw_q       <= 1'b0;
      we_q       <= 1'b0;
      wstrb_q    <= '0;
      wdata_q    <= '0;
      wbValid    <= 1'b0;
      wbData     <= '0;
      wbRd       <= '0;
      wbRegWrite <= 1'b0;
`ifdef MEMACC_MISALIGN_TRAP_EN
      misaligned <= 1'b0;
`endif
    end else begin
      wbValid    <= 1'b0;
      wbRegWrite <= 1'b0;
`ifdef MEMACC_MISALIGN_TRAP_EN
      misaligned <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (take_mem) begin
            alu_q   <= aluResult;
            f3_q    <= funct3;
            rd_q    <= rd;
            rw_q    <= regWrite;
            we_q    <= memWrite & ~memRead;
            wstrb_q <= memRead ? 4'b0000 : sfmt.wstrb;
            wdata_q <= memRead ? 32'h0 : sfmt.wdata;
          end else if (inValid) begin
            wbValid    <= 1'b1;
            wbData     <= aluResult;
            wbRd       <= rd;
            wbRegWrite <= regWrite & ~mis_in;
`ifdef MEMACC_MISALIGN_TRAP_EN
            misaligned <= mis_in;
`endif
          end
        end
        ST_REQ: begin
          if (dmemReqReady && we_q) begin
            wbValid    <= 1'b1;
            wbData     <= alu_q;
            wbRd       <= rd_q;
            wbRegWrite <= rw_q;
          end
        end
        ST_RESP: begin
          if (dmemRspValid) begin
            wbValid    <= 1'b1;
            wbData     <= ld_data;
            wbRd       <= rd_q;
            wbRegWrite <= rw_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Randomized bench for memory_access against a transaction-level reference model.
// Honours MEMACC_MISALIGN_TRAP_EN the same way the design does.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inValid;
  logic [31:0] aluResult;
  logic [31:0] storeData;
  logic        memRead;
  logic        memWrite;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        regWrite;
  logic        stall;
  logic        dmemReqValid;
  logic        dmemReqReady;
  logic [31:0] dmemAddr;
  logic        dmemWe;
  logic [3:0]  dmemWstrb;
  logic [31:0] dmemWdata;
  logic        dmemRspValid;
  logic [31:0] dmemRspData;
  logic        wbValid;
  logic [31:0] wbData;
  logic [4:0]  wbRd;
  logic        wbRegWrite;
  logic        misaligned;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  memory_access #(.XLEN(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inValid      (inValid),
    .aluResult    (aluResult),
    .storeData    (storeData),
    .memRead      (memRead),
    .memWrite     (memWrite),
    .funct3       (funct3),
    .rd           (rd),
    .regWrite     (regWrite),
    .stall        (stall),
    .dmemReqValid (dmemReqValid),
    .dmemReqReady (dmemReqReady),
    .dmemAddr     (dmemAddr),
    .dmemWe       (dmemWe),
    .dmemWstrb    (dmemWstrb),
    .dmemWdata    (dmemWdata),
    .dmemRspValid (dmemRspValid),
    .dmemRspData  (dmemRspData),
    .wbValid      (wbValid),
    .wbData       (wbData),
    .wbRd         (wbRd),
    .wbRegWrite   (wbRegWrite)
`ifdef MEMACC_MISALIGN_TRAP_EN
    ,
    .misaligned   (misaligned)
`endif
  );

`ifndef MEMACC_MISALIGN_TRAP_EN
  assign misaligned = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Access size in bytes from funct3.
  function automatic int sz_of(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic bit is_mis(input logic [2:0] f3, input logic [31:0] a);
    int sz = sz_of(f3);
    return (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] word);
    int sz = sz_of(f3);
    int off;
    logic [31:0] mask, v;
    off  = (sz == 4) ? 0 : (sz == 2) ? (int'(a[1:0]) & 2) : int'(a[1:0]);
    mask = (sz == 1) ? 32'hFF : (sz == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
    v    = (word >> (8 * off)) & mask;
    if (sz < 4 && (f3 == 3'b000 || f3 == 3'b001) && ((v >> (8 * sz - 1)) & 32'd1) == 32'd1)
      v = v | ~mask;
    return v;
  endfunction

  // Presents one instruction (holding it while stall is high) and plays the memory side.
  task automatic run_op(input bit rd_op, input bit wr_op, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [4:0] rdv, input bit rw, input int rdly,
                        input int pdly, input logic [31:0] rword);
    bit is_mem, is_ld, mis, done, accepted, adv;
    int sz, lat, nstall, nreq, wait_rdy, rsp_cnt;
    int exp_lat, exp_stall, exp_req;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;

    is_mem = rd_op | wr_op;
    is_ld  = rd_op;
    mis    = 1'b0;
`ifdef MEMACC_MISALIGN_TRAP_EN
    mis = is_mem && is_mis(f3, addr);
`endif
    sz = sz_of(f3);
    case (sz)
      1: begin
        exp_strb  = 4'(1 << addr[1:0]);
        exp_wdata = {24'b0, sdata[7:0]} * 32'h0101_0101;
      end
      2: begin
        exp_strb  = 4'(3 << (int'(addr[1:0]) & 2));
        exp_wdata = {16'b0, sdata[15:0]} * 32'h0001_0001;
      end
      default: begin
        exp_strb  = 4'hF;
        exp_wdata = sdata;
      end
    endcase
    if (!is_mem || mis) begin
      exp_lat = 1; exp_stall = 0; exp_req = 0;
    end else if (!is_ld) begin
      exp_lat = 2 + rdly; exp_stall = 1 + rdly; exp_req = 1 + rdly;
    end else begin
      exp_lat = 3 + rdly + pdly; exp_stall = 2 + rdly + pdly; exp_req = 1 + rdly;
    end

    inValid = 1'b1; aluResult = addr; storeData = sdata; memRead = rd_op; memWrite = wr_op;
    funct3 = f3; rd = rdv; regWrite = rw;
    lat = 0; nstall = 0; nreq = 0; wait_rdy = 0; rsp_cnt = 0; accepted = 0; done = 0;

    while (!done && lat < 200) begin
      dmemRspData = $urandom;
      dmemRspValid = 1'b0;
      if (!accepted) dmemRspValid = 1'($urandom % 2);
      else if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          dmemRspValid = 1'b1;
          dmemRspData  = rword;
        end
      end
      if (dmemReqValid) begin
        nreq++;
        dmemReqReady = 1'b0;
        if (wait_rdy == rdly) begin
          dmemReqReady = 1'b1;
          accepted = 1'b1;
          rsp_cnt = pdly + 1;
          chk("req_addr", dmemAddr, {addr[31:2], 2'b00});
          chk("req_we", 32'(dmemWe), 32'(!is_ld));
          if (!is_ld) begin
            chk("req_strb", 32'(dmemWstrb), 32'(exp_strb));
            chk("req_wdata", dmemWdata, exp_wdata);
          end
        end else wait_rdy++;
      end else dmemReqReady = 1'($urandom % 2);
      #1;
      if (stall) nstall++;
      adv = !stall;
      @(posedge clk); #1;
      lat++;
      if (adv) begin
        inValid = 1'b0; memRead = 1'b0; memWrite = 1'b0; aluResult = $urandom;
      end
      if (wbValid) begin
        done = 1'b1;
        if (is_ld && !mis) chk("wb_data", wbData, model_load(f3, addr, rword));
        else if (!is_mem || mis) chk("wb_data", wbData, addr);
        chk("wb_rd", 32'(wbRd), 32'(rdv));
        chk("wb_regwrite", 32'(wbRegWrite), 32'(rw && !mis));
`ifdef MEMACC_MISALIGN_TRAP_EN
        chk("misaligned", 32'(misaligned), 32'(mis));
`endif
      end
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("stall_cycles", 32'(nstall), 32'(exp_stall));
    chk("req_cycles", 32'(nreq), 32'(exp_req));

    // One idle cycle with stray handshakes: no second pulse, back in IDLE.
    inValid = 1'b0;
    dmemRspValid = 1'($urandom % 2);
    dmemReqReady = 1'($urandom % 2);
    @(posedge clk); #1;
    chk("single_pulse", 32'(wbValid), 32'd0);
    chk("idle_noreq", 32'(dmemReqValid), 32'd0);
    dmemRspValid = 1'b0;
    dmemReqReady = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_reqvalid"}, 32'(dmemReqValid), 32'd0);
    chk({tag, "_addr"}, dmemAddr, 32'd0);
    chk({tag, "_we"}, 32'(dmemWe), 32'd0);
    chk({tag, "_strb"}, 32'(dmemWstrb), 32'd0);
    chk({tag, "_wdata"}, dmemWdata, 32'd0);
    chk({tag, "_wbvalid"}, 32'(wbValid), 32'd0);
    chk({tag, "_wbdata"}, wbData, 32'd0);
    chk({tag, "_wbrd"}, 32'(wbRd), 32'd0);
    chk({tag, "_wbregwrite"}, 32'(wbRegWrite), 32'd0);
    chk({tag, "_misaligned"}, 32'(misaligned), 32'd0);
  endtask

  initial begin
    resetn = 1'b0; inValid = 1'b0; aluResult = '0; storeData = '0; memRead = 1'b0;
    memWrite = 1'b0; funct3 = '0; rd = '0; regWrite = 1'b0; dmemReqReady = 1'b0;
    dmemRspValid = 1'b0; dmemRspData = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    resetn = 1'b1;
    @(posedge clk); #1;

    run_op(0, 0, 3'b000, 32'h1234_5678, 32'h0, 5'd5, 1, 0, 0, 32'h0);
    run_op(0, 1, 3'b000, 32'h0000_0103, 32'h0000_00AB, 5'd0, 0, 0, 0, 32'h0);
    run_op(1, 0, 3'b000, 32'h0000_0102, 32'h0, 5'd7, 1, 0, 0, 32'h0080_0000);
    run_op(1, 0, 3'b100, 32'h0000_0102, 32'h0, 5'd8, 1, 0, 0, 32'h0080_0000);
    run_op(1, 0, 3'b001, 32'h0000_0002, 32'h0, 5'd9, 1, 3, 2, 32'hBEEF_1234);
    run_op(1, 0, 3'b010, 32'h0000_0101, 32'h0, 5'd10, 1, 0, 0, 32'hCAFE_F00D);
    run_op(1, 1, 3'b010, 32'h0000_0200, 32'h5555_5555, 5'd11, 1, 1, 1, 32'h0BAD_CAFE);

    // Reset while a load waits in RESP.
    inValid = 1'b1; memRead = 1'b1; memWrite = 1'b0; funct3 = 3'b010;
    aluResult = 32'h40; rd = 5'd3; regWrite = 1'b1;
    @(posedge clk); #1;
    dmemReqReady = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0; memRead = 1'b0; dmemReqReady = 1'b0;
    chk("resp_wait_stall", 32'(stall), 32'd1);
    resetn = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(posedge clk); #1;
    resetn = 1'b1;
    dmemRspValid = 1'b1; dmemRspData = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    chk("late_rsp_ignored", 32'(wbValid), 32'd0);
    dmemRspValid = 1'b0;

    for (int i = 0; i < 40; i++) begin
      int kind;
      logic [2:0] f3;
      kind = int'($urandom % 4);
      f3 = 3'($urandom % 8);
      run_op(kind == 1 || kind == 3, kind == 2 || kind == 3, f3, $urandom, $urandom,
             5'($urandom), 1'($urandom % 2), int'($urandom % 4), int'($urandom % 3), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_access.md
# memory_access

Memory stage of the five-stage RV32 pipeline, directly downstream of the execute stage. It takes the ALU result and the forwarded store operand, runs loads and stores against data memory over a valid/ready request channel with a separate response channel, and holds the pipeline while an access is outstanding. It formats load data with lane selection and sign or zero extension, and registers the result into the MEM/WB boundary. Non-memory instructions pass through with one cycle of latency.

## Interface
Parameters:
- XLEN, 32: datapath width. Only 32 is supported.

Ports:
- clk  in  1  clock. All state is updated on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- inValid  in  1  an instruction is present on the inputs this cycle.
- aluResult  in  32  ALU result from execute. It is the effective address for memory ops.
- storeData  in  32  forwarded rs2 value for stores.
- memRead  in  1  the instruction is a load.
- memWrite  in  1  the instruction is a store.
- funct3  in  3  access size and signedness (RV32 load/store encoding).
- rd  in  5  destination register.
- regWrite  in  1  the instruction writes rd.
- stall  out  1  combinational. When high, upstream stages hold their outputs.
- dmemReqValid  out  1  a data memory request is being offered.
- dmemReqReady  in  1  memory accepts the request.
- dmemAddr  out  32  word-aligned address: aluResult[31:2] followed by 2'b00.
- dmemWe  out  1  1 for a store request, 0 for a load request.
- dmemWstrb  out  4  byte-lane write strobe.
- dmemWdata  out  32  store data, already lane-replicated.
- dmemRspValid  in  1  load response is valid.
- dmemRspData  in  32  load response word.
- wbValid  out  1  an instruction retired into MEM/WB this cycle.
- wbData  out  32  the loaded value, or aluResult for non-memory ops.
- wbRd  out  5  registered rd.
- wbRegWrite  out  1  registered regWrite, qualified by wbValid.
- misaligned  out  1  only present when MEMACC_MISALIGN_TRAP_EN is defined; see Configuration.

## Operation
The stage is controlled by a three-state FSM: IDLE, REQ, RESP.

IDLE:
- Non-memory instruction: the MEM/WB registers capture the instruction at the next edge and the stage stays in IDLE.
- Load or store: the stage latches the address, funct3, rd, regWrite, and the formatted store data/strobe, then goes to REQ.

REQ:
- dmemReqValid is held high.
- The request fields are stable until dmemReqReady is sampled high.
- On acceptance, a store retires and the stage returns to IDLE. A load goes to RESP.

RESP:
- The stage waits for dmemRspValid. On that edge it captures the formatted data into wbData and returns to IDLE.
- The memory returns the response no earlier than the cycle after acceptance.
- dmemRspValid seen in any state other than RESP is ignored.

stall = (IDLE & inValid & (memRead | memWrite)) | (REQ & !(dmemReqReady & dmemWe)) | (RESP & !dmemRspValid).
- stall drops in the completion cycle, so upstream advances exactly once per instruction.
- The held instruction is never re-issued.

Store formatting, using offset = aluResult[1:0]:
- SB: data byte replicated ×4, strobe = 4'b0001 << offset.
- SH: data half replicated ×2, strobe = 4'b0011 << {offset[1],1'b0}.
- SW: strobe 4'b1111.

Load formatting:
- Selects the byte or half lane at offset.
- LB and LH sign-extend. LBU and LHU zero-extend. LW passes the word through.

Other rules:
- memRead and memWrite both high is illegal and treated as a load.
- Any other funct3 is treated as a word access.
- wbValid is a single-cycle pulse for each retired instruction.

## Timing
- Reset values: state=IDLE; wbValid, wbData, wbRd, wbRegWrite, dmemReqValid, dmemWe, dmemWstrb, dmemAddr, dmemWdata, misaligned all 0.
- Reset mid-access abandons the request. Memory must tolerate a dropped dmemReqValid.
- Non-memory op presented at cycle N: wbValid at N+1.
- Store presented at N with immediate ready: REQ at N+1, accepted at N+1, stall low at N+1, wbValid at N+2.
- Load with immediate ready and a 1-cycle response: REQ at N+1, RESP at N+2 with rvalid, wbValid at N+3. stall is high from N to N+1 and low at N+2.
- Each cycle that dmemReqReady or dmemRspValid is late adds one cycle of latency.

## Configuration
- MEMACC_MISALIGN_TRAP_EN defined:
  - A halfword access with offset[0]=1, or a word access with offset≠0, issues no request.
  - The instruction retires in IDLE at the next edge with wbValid=1, wbRegWrite=0, and misaligned=1 for that one cycle.
  - stall is not asserted for it.
- Undefined:
  - The misaligned output is absent.
  - Offsets are masked to the natural alignment: a halfword uses offset[1], a word uses 0.
  - The access proceeds normally.

## Structure
- Shared package memacc_pkg holds:
  - the FSM state enum;
  - funct3 localparams (F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101);
  - a store-format function and a load-format function.
- One sub-module, load_align, holds the combinational lane select and extension of dmemRspData.

## Test plan
- ALU op: aluResult=0x12345678, rd=5, regWrite=1 -> next cycle wbValid=1, wbData=0x12345678, wbRd=5, stall never high.
- SB: addr 0x103, storeData=0xAB -> dmemAddr=0x100, dmemWstrb=4'b1000, dmemWdata=0xABABABAB, dmemWe=1, wbValid two cycles after presentation.
- LB: addr 0x102, response 0x00800000 -> wbData=0xFFFFFF80. LBU at the same address gives 0x00000080.
- LH: addr 0x002, dmemReqReady delayed 3 cycles, response delayed 2 more cycles -> stall high continuously until the response cycle, then exactly one wbValid with wbData from bits [31:16].
- resetn asserted while in RESP -> every output is 0 immediately, the FSM is in IDLE, and a late dmemRspValid produces no wbValid.
- MEMACC_MISALIGN_TRAP_EN defined, LW at 0x101 -> no dmemReqValid, a one-cycle misaligned=1 pulse with wbValid=1 and wbRegWrite=0.
